pc_sequencer: RTL and testbench

- Owns the architectural PC and sequences instruction fetch for the single-issue core.
- Each cycle it selects the next PC from three sources: sequential PC+4, branch target (PC+4 + (imm << 2)), or absolute jump target.
- Issues one outstanding fetch to instruction memory over a valid/ready handshake and forwards returned instructions to decode with backpressure.
- Drops in-flight fetches that a branch or jump redirect has made stale.

---
 rtl/pc_seq_pkg.sv | 15 +
 rtl/pc_sequencer_if.sv | 26 ++
 rtl/pc_next_sel.sv | 37 +++
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding,
// default reset/trap vectors and the instruction size in bytes.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0080;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle: instruction-memory request/response and the decode
// handshake. The sequencer uses the master modport; memory/decode use slave.
interface pc_sequencer_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, instr_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready
  );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: sequential, branch and jump targets with
// branch-over-jump priority. Alignment handling depends on MISALIGN_TRAP_EN.
module pc_next_sel
  import pc_seq_pkg::*;
(
  input  logic [31:0] seq_base_i,
  output logic [31:0] seq_pc_o,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_pc_plus4_i,
  input  logic [31:0] branch_imm_i,
  input  logic        jump_valid_i,
  input  logic [31:0] jump_target_i,
  output logic        redirect_o,
  output logic [31:0] target_o,
  output logic        misalign_o
);

  logic [31:0] raw_target;

  always_comb begin
    seq_pc_o   = seq_base_i + INSTR_BYTES;
    redirect_o = branch_taken_i | jump_valid_i;
    raw_target = jump_target_i;
    if (branch_taken_i) begin
      raw_target = branch_pc_plus4_i + (branch_imm_i << 2);
    end
`ifdef MISALIGN_TRAP_EN
    misalign_o = redirect_o && (raw_target[1:0] != 2'b00);
    target_o   = raw_target;
`else
    // Without trapping, a misaligned target silently rounds down to a word.
    misalign_o = 1'b0;
    target_o   = raw_target & ~32'h3;
`endif
  end

endmodule

// File: rtl/pc_sequencer.sv
// PC owner and single-outstanding fetch sequencer (REQ -> WAIT -> HOLD).
// Define MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_VECTOR.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF
`ifdef MISALIGN_TRAP_EN
  , parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pc_sequencer_if.master        bus,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_pc_plus4,
  input  logic [31:0]           branch_imm,
  input  logic                  jump_valid,
  input  logic [31:0]           jump_target,
  output logic                  misalign_trap
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic [31:0] instr_pc4_q, instr_pc4_d;

  logic        redirect;
  logic        misalign;
  logic [31:0] target;
  logic [31:0] seq_pc;
  logic [31:0] redir_pc;

  pc_next_sel u_next_sel (
    .seq_base_i        (fetch_pc_q),
    .seq_pc_o          (seq_pc),
    .branch_taken_i    (branch_taken),
    .branch_pc_plus4_i (branch_pc_plus4),
    .branch_imm_i      (branch_imm),
    .jump_valid_i      (jump_valid),
    .jump_target_i     (jump_target),
    .redirect_o        (redirect),
    .target_o          (target),
    .misalign_o        (misalign)
  );

`ifdef MISALIGN_TRAP_EN
  assign redir_pc = misalign ? TRAP_VECTOR : target;
`else
  assign redir_pc = target;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    addr_d      = addr_q;
    fetch_pc_d  = fetch_pc_q;
    drop_d      = drop_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    instr_pc4_d = instr_pc4_q;
    case (state_q)
      REQ: begin
        // addr_q keeps the request stable; only pc follows the redirect.
        if (redirect) begin
          pc_d   = redir_pc;
          drop_d = 1'b1;
        end
        if (bus.imem_req_ready) begin
          state_d    = WAIT;
          fetch_pc_d = addr_q;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (drop_q || redirect) begin
            drop_d  = 1'b0;
            state_d = REQ;
            pc_d    = redirect ? redir_pc : pc_q;
            addr_d  = redirect ? redir_pc : pc_q;
          end else begin
            instr_d     = bus.imem_rsp_data;
            instr_pc_d  = fetch_pc_q;
            instr_pc4_d = seq_pc;
            pc_d        = seq_pc;
            state_d     = HOLD;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
          pc_d   = redir_pc;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redir_pc;
          addr_d  = redir_pc;
          state_d = REQ;
        end else if (bus.instr_ready) begin
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_VECTOR;
      addr_q      <= RESET_VECTOR;
      fetch_pc_q  <= RESET_VECTOR;
      drop_q      <= 1'b0;
      instr_q     <= '0;
      instr_pc_q  <= '0;
      instr_pc4_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_q      <= drop_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      instr_pc4_q <= instr_pc4_d;
    end
  end

  // Request is held off while reset is asserted even though state is REQ.
  assign bus.imem_req_valid = (state_q == REQ) && rst_n;
  assign bus.imem_addr      = addr_q;
  assign bus.instr_valid    = (state_q == HOLD);
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.instr_pc_plus4 = instr_pc4_q;
  assign misalign_trap      = misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table for free-run and a dropped
// branch, then hand sequences for stall/redirect, wrap, trap and reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_pc_plus4;
  logic [31:0] branch_imm;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        misalign_trap;

  int n_chk  = 0;
  int n_fail = 0;

  pc_sequencer_if bus();

  pc_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .branch_taken    (branch_taken),
    .branch_pc_plus4 (branch_pc_plus4),
    .branch_imm      (branch_imm),
    .jump_valid      (jump_valid),
    .jump_target     (jump_target),
    .misalign_trap   (misalign_trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        irdy;
    logic        br;
    logic [31:0] bpc4;
    logic [31:0] imm;
    logic        jv;
    logic [31:0] jt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: answers one cycle after acceptance with ~addr as data.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = bus.imem_req_valid & bus.imem_req_ready;
    a   = bus.imem_addr;
    @(posedge clk);
    #1;
    bus.imem_rsp_valid = acc;
    bus.imem_rsp_data  = ~a;
    branch_taken       = 1'b0;
    jump_valid         = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_trap_addr;
    logic [31:0] exp_trap;
`ifdef MISALIGN_TRAP_EN
    exp_trap_addr = 32'h0000_0080;
    exp_trap      = 32'd1;
`else
    exp_trap_addr = 32'h0000_0300;
    exp_trap      = 32'd0;
`endif

    //          rdy irdy br bpc4          imm           jv jt  req addr          iv ipc           instr
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,   32'h0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h0,   32'hFFFF_FFFF};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b0, 32'h0,   32'h0};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h4,   32'hFFFF_FFFB};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b1, 32'h0000_0008, 1'b0, 32'h0,   32'h0};
    vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h0};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h8,   32'hFFFF_FFF7};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b1, 32'h0000_000C, 1'b0, 32'h0,   32'h0};
    vt[10] = '{1'b1, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h0};
    vt[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b1, 32'h0000_00F8, 1'b0, 32'h0,   32'h0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'hF8,  32'hFFFF_FF07};
    vt[14] = '{1'b1, 1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'h0, 1'b1, 32'h0000_00FC, 1'b0, 32'h0,   32'h0};

    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.instr_ready    = 1'b0;
    branch_taken       = 1'b0;
    branch_pc_plus4    = 32'h0;
    branch_imm         = 32'h0;
    jump_valid         = 1'b0;
    jump_target        = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_instr_pc4", bus.instr_pc_plus4, 32'h0);
    chk("rst_misalign", {31'b0, misalign_trap}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      bus.imem_req_ready = vt[i].rdy;
      bus.instr_ready    = vt[i].irdy;
      branch_taken       = vt[i].br;
      branch_pc_plus4    = vt[i].bpc4;
      branch_imm         = vt[i].imm;
      jump_valid         = vt[i].jv;
      jump_target        = vt[i].jt;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'b0, bus.imem_req_valid}, {31'b0, vt[i].e_req});
      if (vt[i].e_req) chk($sformatf("v%0d_addr", i), bus.imem_addr, vt[i].e_addr);
      chk($sformatf("v%0d_instr_valid", i), {31'b0, bus.instr_valid}, {31'b0, vt[i].e_iv});
      if (vt[i].e_iv) begin
        chk($sformatf("v%0d_instr_pc", i), bus.instr_pc, vt[i].e_ipc);
        chk($sformatf("v%0d_instr", i), bus.instr, vt[i].e_instr);
        chk($sformatf("v%0d_instr_pc4", i), bus.instr_pc_plus4, vt[i].e_ipc + 32'd4);
      end
      tick();
    end

    // Branch and jump together while WAIT: branch must win.
    branch_taken = 1'b1; branch_pc_plus4 = 32'h200; branch_imm = 32'h0;
    jump_valid   = 1'b1; jump_target     = 32'h400;
    tick();
    chk("prio_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("prio_addr", bus.imem_addr, 32'h200);
    tick();
    tick();
    chk("prio_instr_pc", bus.instr_pc, 32'h200);
    chk("prio_instr_valid", {31'b0, bus.instr_valid}, 32'd1);
    tick();
    chk("prio_next_addr", bus.imem_addr, 32'h204);

    // Request stalled 5 cycles, jump to 0x300 mid-stall.
    bus.imem_req_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk($sformatf("stall%0d_req_valid", s), {31'b0, bus.imem_req_valid}, 32'd1);
      chk($sformatf("stall%0d_addr", s), bus.imem_addr, 32'h204);
      if (s == 2) begin
        jump_valid  = 1'b1;
        jump_target = 32'h300;
      end
      tick();
    end
    bus.imem_req_ready = 1'b1;
    #1;
    chk("stall_accept_addr", bus.imem_addr, 32'h204);
    tick();
    chk("stall_wait_iv", {31'b0, bus.instr_valid}, 32'd0);
    tick();
    chk("stall_drop_iv", {31'b0, bus.instr_valid}, 32'd0);
    chk("stall_next_addr", bus.imem_addr, 32'h300);

    // Jump to the top word, hold decode 4 cycles, then wrap to 0.
    tick();
    jump_valid = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_req_addr", bus.imem_addr, 32'hFFFF_FFFC);
    bus.instr_ready = 1'b0;
    tick();
    tick();
    for (int h = 0; h < 4; h++) begin
      chk($sformatf("hold%0d_iv", h), {31'b0, bus.instr_valid}, 32'd1);
      chk($sformatf("hold%0d_instr_pc", h), bus.instr_pc, 32'hFFFF_FFFC);
      chk($sformatf("hold%0d_instr", h), bus.instr, 32'h0000_0003);
      chk($sformatf("hold%0d_req_valid", h), {31'b0, bus.imem_req_valid}, 32'd0);
      tick();
    end
    chk("wrap_pc4", bus.instr_pc_plus4, 32'h0);
    bus.instr_ready = 1'b1;
    tick();
    chk("wrap_next_addr", bus.imem_addr, 32'h0);
    chk("wrap_next_req", {31'b0, bus.imem_req_valid}, 32'd1);

    // Misaligned jump target 0x302 during WAIT.
    tick();
    jump_valid = 1'b1; jump_target = 32'h302;
    #1;
    chk("misalign_pulse", {31'b0, misalign_trap}, exp_trap);
    tick();
    chk("misalign_after", {31'b0, misalign_trap}, 32'd0);
    chk("misalign_addr", bus.imem_addr, exp_trap_addr);

    // Redirect in HOLD drops the shown instruction.
    tick();
    tick();
    bus.instr_ready = 1'b0;
    branch_taken = 1'b1; branch_pc_plus4 = 32'h500; branch_imm = 32'h1;
    #1;
    chk("holdredir_iv", {31'b0, bus.instr_valid}, 32'd1);
    tick();
    chk("holdredir_iv_after", {31'b0, bus.instr_valid}, 32'd0);
    chk("holdredir_addr", bus.imem_addr, 32'h504);
    bus.instr_ready = 1'b1;

    // Asynchronous reset mid-fetch; a stray response afterwards is ignored.
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    chk("midrst_addr", bus.imem_addr, 32'h0);
    chk("midrst_iv", {31'b0, bus.instr_valid}, 32'd0);
    tick();
    rst_n = 1'b1;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_BEEF;
    #1;
    chk("postrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    chk("postrst_addr", bus.imem_addr, 32'h0);
    tick();
    chk("stray_iv", {31'b0, bus.instr_valid}, 32'd0);
    chk("stray_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    bus.imem_req_ready = 1'b1;
    tick();
    tick();
    chk("postrst_iv", {31'b0, bus.instr_valid}, 32'd1);
    chk("postrst_instr_pc", bus.instr_pc, 32'h0);
    chk("postrst_instr", bus.instr, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
